mdio_slave_c22: RTL and testbench

Parametrised Clause-22 MDIO management slave (PHY side), successor to the fixed single-address receptor. It deserialises full 32-bit management frames (ST, OP, PHYAD, REGAD, TA, DATA) sampled on MDC. It filters on a configurable PHY address, enforces an optional preamble, and serves reads and writes against an internal register file with read-only protection. It sits between the MDIO master's serial lines and the PHY configuration registers.

---
 rtl/mdio_pkg.sv | 23 ++
 rtl/mdio_regfile.sv | 36 +++
 rtl/mdio_slave_c22.sv | 178 +++++++++++++++++
 tb/tb_mdio_slave_c22.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared encodings and bit-index constants for the Clause-22 MDIO slave.
package mdio_pkg;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        HDR  = 6'b000010,
        RD   = 6'b000100,
        WR   = 6'b001000,
        SKIP = 6'b010000,
        DONE = 6'b100000
    } state_t;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam logic [4:0] K_REGAD_LAST = 5'd13;
    localparam logic [4:0] K_TA1        = 5'd14;
    localparam logic [4:0] K_TA2        = 5'd15;
    localparam logic [4:0] K_LAST       = 5'd31;

endpackage

// File: rtl/mdio_regfile.sv
// PHY register file: combinational read, gated synchronous write, per-register read-only mask.
module mdio_regfile
    import mdio_pkg::*;
#(
    parameter int          NUM_REGS  = 32,
    parameter logic [31:0] RO_MASK   = 32'h0000_000C,
    parameter logic [15:0] REG3_INIT = 16'h3AAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        wr_ok
);

    logic [15:0] regs [32];
    logic        in_range;

    assign in_range = {27'd0, addr} < NUM_REGS;
    assign wr_ok    = wr_en && in_range && !RO_MASK[addr];
    assign rd_data  = in_range ? regs[addr] : 16'h0000;

    // Entries at or above NUM_REGS are never written, so they stay constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 3) ? REG3_INIT : 16'h0000;
            end
        end else if (wr_ok) begin
            regs[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/mdio_slave_c22.sv
// Clause-22 MDIO management slave: frame deserialiser, PHY-address filter,
// optional preamble check, and read/write access to mdio_regfile.
module mdio_slave_c22
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          NUM_REGS     = 32,
    parameter int          PREAMBLE_LEN = 0,
    parameter logic [31:0] RO_MASK      = 32'h0000_000C,
    parameter logic [15:0] REG3_INIT    = 16'h3AAA
) (
    input  logic        MDC,
    input  logic        RESET,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        MDIO_DONE,
    output logic        FRAME_ERR
);

    localparam int               PRE_W   = (PREAMBLE_LEN > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_LEN);

    state_t           state, state_nxt;
    logic [4:0]       bit_cnt, cnt_nxt;
    logic [PRE_W-1:0] pre_cnt, pre_nxt;

    logic [11:0] hdr_sr;
    logic [14:0] data_sr;
    logic [15:0] rd_sr, rd_sr_nxt;
    logic [12:0] hdr;
    logic [1:0]  op;
    logic [4:0]  phyad, regad;

    logic [4:0]  addr_nxt;
    logic [15:0] wr_data_nxt, rd_data;
    logic        in_nxt, done_nxt, err_nxt, wr_en, wr_ok;

    // At the K_REGAD_LAST edge hdr holds bits k=1..13: ST[0], OP, PHYAD, REGAD.
    assign hdr   = {hdr_sr, MDIO_OUT};
    assign op    = hdr[11:10];
    assign phyad = hdr[9:5];
    assign regad = hdr[4:0];

    mdio_regfile #(
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK),
        .REG3_INIT(REG3_INIT)
    ) u_regfile (
        .clk    (MDC),
        .rst    (RESET),
        .wr_en  (wr_en),
        .addr   (ADDR),
        .wr_data({data_sr, MDIO_OUT}),
        .rd_data(rd_data),
        .wr_ok  (wr_ok)
    );

    always_ff @(posedge MDC or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            bit_cnt <= '0;
            pre_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            pre_cnt <= pre_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_cnt + 5'd1;
        pre_nxt     = pre_cnt;
        addr_nxt    = ADDR;
        wr_data_nxt = WR_DATA;
        rd_sr_nxt   = rd_sr;
        in_nxt      = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        wr_en       = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!MDIO_OE) begin
                    pre_nxt = '0;
                end else if (MDIO_OUT) begin
                    if (pre_cnt != PRE_MAX) pre_nxt = pre_cnt + PRE_W'(1);
                end else if (pre_cnt >= PRE_MAX) begin
                    state_nxt = HDR;
                    cnt_nxt   = 5'd1;
                    pre_nxt   = '0;
                end else begin
                    pre_nxt = '0;
                end
            end
            HDR: begin
                if (!MDIO_OE) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (bit_cnt == K_REGAD_LAST) begin
                    if ({1'b0, hdr[12]} != ST_CODE || (op != OP_READ && op != OP_WRITE)) begin
                        err_nxt   = 1'b1;
                        state_nxt = SKIP;
                    end else if (phyad != PHY_ADDR) begin
                        state_nxt = SKIP;
                    end else begin
                        addr_nxt  = regad;
                        state_nxt = (op == OP_READ) ? RD : WR;
                    end
                end
            end
            SKIP: begin
                if (bit_cnt == K_LAST) state_nxt = IDLE;
            end
            WR: begin
                if (!MDIO_OE ||
                    (bit_cnt == K_TA1 && MDIO_OUT != TA_WRITE[1]) ||
                    (bit_cnt == K_TA2 && MDIO_OUT != TA_WRITE[0])) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (bit_cnt == K_LAST) begin
                    wr_en       = 1'b1;
                    wr_data_nxt = {data_sr, MDIO_OUT};
                    done_nxt    = 1'b1;
                    state_nxt   = DONE;
                end
            end
            RD: begin
                // The master has released the line; MDIO_OE is not checked here.
                if (bit_cnt == K_TA1) begin
                    rd_sr_nxt = rd_data;
                end else if (bit_cnt == K_LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (bit_cnt > K_TA1) begin
                    in_nxt    = rd_sr[15];
                    rd_sr_nxt = {rd_sr[14:0], 1'b0};
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge MDC or posedge RESET) begin
        if (RESET) begin
            MDIO_IN   <= 1'b0;
            ADDR      <= '0;
            WR_DATA   <= '0;
            WR_STB    <= 1'b0;
            MDIO_DONE <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            MDIO_IN   <= in_nxt;
            ADDR      <= addr_nxt;
            WR_DATA   <= wr_data_nxt;
            WR_STB    <= wr_ok;
            MDIO_DONE <= done_nxt;
            FRAME_ERR <= err_nxt;
        end
    end

    // Free-running shifters: only their contents at the decode/last edges matter.
    always_ff @(posedge MDC) begin
        hdr_sr  <= {hdr_sr[10:0], MDIO_OUT};
        data_sr <= {data_sr[13:0], MDIO_OUT};
        rd_sr   <= rd_sr_nxt;
    end

endmodule

// File: tb/tb_mdio_slave_c22.sv
// Directed bench for mdio_slave_c22: a default instance plus one requiring a 32-bit preamble.
module tb_mdio_slave_c22;

    logic MDC = 1'b0;
    logic RESET = 1'b0;
    logic MDIO_OUT = 1'b1;
    logic MDIO_OE = 1'b0;

    logic        in1, stb1, done1, err1, in2, stb2, done2, err2;
    logic [4:0]  addr1, addr2;
    logic [15:0] wd1, wd2;

    mdio_slave_c22 #(
        .PHY_ADDR(5'd1), .NUM_REGS(32), .PREAMBLE_LEN(0),
        .RO_MASK(32'h0000_000C), .REG3_INIT(16'h3AAA)
    ) u_dut (
        .MDC(MDC), .RESET(RESET), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
        .MDIO_IN(in1), .ADDR(addr1), .WR_DATA(wd1), .WR_STB(stb1),
        .MDIO_DONE(done1), .FRAME_ERR(err1)
    );

    mdio_slave_c22 #(
        .PHY_ADDR(5'd1), .NUM_REGS(32), .PREAMBLE_LEN(32),
        .RO_MASK(32'h0000_000C), .REG3_INIT(16'h3AAA)
    ) u_pre (
        .MDC(MDC), .RESET(RESET), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
        .MDIO_IN(in2), .ADDR(addr2), .WR_DATA(wd2), .WR_STB(stb2),
        .MDIO_DONE(done2), .FRAME_ERR(err2)
    );

    always #5 MDC = ~MDC;

    logic        sel = 1'b0;
    logic        m_in, m_stb, m_done, m_err;
    logic [4:0]  m_addr;
    logic [15:0] m_wd;

    assign m_in   = sel ? in2   : in1;
    assign m_stb  = sel ? stb2  : stb1;
    assign m_done = sel ? done2 : done1;
    assign m_err  = sel ? err2  : err1;
    assign m_addr = sel ? addr2 : addr1;
    assign m_wd   = sel ? wd2   : wd1;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt, stb_cnt, err_cnt;
    logic        done31, stb31;
    logic [4:0]  addr31;
    logic [15:0] wd31, rd_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic drive_bit(input logic oe, input logic d);
        MDIO_OE  = oe;
        MDIO_OUT = d;
        @(posedge MDC);
        @(negedge MDC);
        if (m_done === 1'b1) done_cnt++;
        if (m_stb === 1'b1) stb_cnt++;
        if (m_err === 1'b1) err_cnt++;
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        stb_cnt  = 0;
        err_cnt  = 0;
    endtask

    task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] data, input int drop_k);
        logic [31:0] w;
        logic        is_rd;
        w      = {2'b01, op, phy, ra, 2'b10, data};
        is_rd  = (op == 2'b10);
        rd_val = 16'h0000;
        clear_counts();
        repeat (npre) drive_bit(1'b1, 1'b1);
        for (int k = 0; k < 32; k++) begin
            drive_bit(is_rd ? (k < 14) : (k < drop_k), w[31-k]);
            if (k >= 15 && k <= 30) rd_val[30-k] = m_in;
            if (k == 31) begin
                done31 = m_done;
                stb31  = m_stb;
                addr31 = m_addr;
                wd31   = m_wd;
            end
        end
        repeat (2) drive_bit(1'b0, 1'b1);
    endtask

    task automatic read_chk(input string tag, input logic [4:0] ra, input logic [15:0] exp);
        frame(0, 2'b10, 5'd1, ra, 16'h0000, 32);
        chk({tag, "_data"}, rd_val, exp);
        chk({tag, "_done"}, done_cnt, 1);
    endtask

    initial begin
        logic [31:0] w;

        @(negedge MDC);
        RESET = 1'b1;
        #1;
        chk("rst_outs", {in1, addr1, wd1, stb1, done1, err1}, 0);
        chk("rst_outs_pre", {in2, addr2, wd2, stb2, done2, err2}, 0);
        repeat (2) @(negedge MDC);
        RESET = 1'b0;
        repeat (2) drive_bit(1'b0, 1'b1);

        // Read of the ID register after reset.
        frame(0, 2'b10, 5'd1, 5'd3, 16'h0000, 32);
        chk("rd3_data", rd_val, 16'h3AAA);
        chk("rd3_done31", done31, 1);
        chk("rd3_done_cnt", done_cnt, 1);
        chk("rd3_stb_cnt", stb_cnt, 0);
        chk("rd3_err_cnt", err_cnt, 0);
        chk("rd3_addr", addr31, 5'd3);

        // Accepted write, then read back.
        frame(0, 2'b01, 5'd1, 5'd5, 16'hBEEF, 32);
        chk("wr5_addr", addr31, 5'd5);
        chk("wr5_wdata", wd31, 16'hBEEF);
        chk("wr5_stb31", stb31, 1);
        chk("wr5_done31", done31, 1);
        chk("wr5_stb_cnt", stb_cnt, 1);
        chk("wr5_done_cnt", done_cnt, 1);
        chk("wr5_err_cnt", err_cnt, 0);
        read_chk("rd5_a", 5'd5, 16'hBEEF);

        // Write to another PHY address is silently ignored.
        frame(0, 2'b01, 5'd2, 5'd5, 16'h1234, 32);
        chk("phy2_done_cnt", done_cnt, 0);
        chk("phy2_stb_cnt", stb_cnt, 0);
        chk("phy2_err_cnt", err_cnt, 0);
        read_chk("rd5_b", 5'd5, 16'hBEEF);

        // Write to a read-only register completes but does not store.
        frame(0, 2'b01, 5'd1, 5'd2, 16'hFFFF, 32);
        chk("ro2_done31", done31, 1);
        chk("ro2_done_cnt", done_cnt, 1);
        chk("ro2_stb_cnt", stb_cnt, 0);
        chk("ro2_wdata", wd31, 16'hFFFF);
        read_chk("rd2", 5'd2, 16'h0000);

        // Aborted write and illegal opcode.
        frame(0, 2'b01, 5'd1, 5'd5, 16'h5555, 20);
        chk("abort_err_cnt", err_cnt, 1);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_stb_cnt", stb_cnt, 0);
        frame(0, 2'b11, 5'd1, 5'd5, 16'h5555, 32);
        chk("op11_err_cnt", err_cnt, 1);
        chk("op11_done_cnt", done_cnt, 0);
        chk("op11_stb_cnt", stb_cnt, 0);
        read_chk("rd5_c", 5'd5, 16'hBEEF);

        // Preamble enforcement on the second instance.
        sel = 1'b1;
        frame(31, 2'b10, 5'd1, 5'd3, 16'h0000, 32);
        chk("pre31_done_cnt", done_cnt, 0);
        chk("pre31_data", rd_val, 16'h0000);
        frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 32);
        chk("pre32_done_cnt", done_cnt, 1);
        chk("pre32_data", rd_val, 16'h3AAA);
        sel = 1'b0;

        // Reset in the middle of a write header.
        w = {2'b01, 2'b01, 5'd1, 5'd7, 2'b10, 16'hCAFE};
        for (int k = 0; k < 9; k++) drive_bit(1'b1, w[31-k]);
        RESET = 1'b1;
        #1;
        chk("midrst_outs", {in1, addr1, wd1, stb1, done1, err1}, 0);
        repeat (2) @(negedge MDC);
        RESET = 1'b0;
        clear_counts();
        repeat (3) drive_bit(1'b0, 1'b1);
        chk("midrst_pulses", done_cnt + stb_cnt + err_cnt, 0);
        read_chk("rd5_after_rst", 5'd5, 16'h0000);
        read_chk("rd7_after_rst", 5'd7, 16'h0000);
        read_chk("rd3_after_rst", 5'd3, 16'h3AAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
